// File: rtl/ldffe_pipe.sv
// rtl/ldffe_pipe.sv - shift pipeline with synchronous reset, parallel load, enable and fill tracking
module ldffe_pipe #(
  parameter int               WIDTH   = 4,
  parameter int               DEPTH   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter bit               EN_POL  = 1'b1
) (
  input  logic                             clk,
  input  logic                             srst,
  input  logic                             en,
  input  logic                             load,
  input  logic [WIDTH-1:0]                 ad,
  input  logic [WIDTH-1:0]                 d,
  output logic [WIDTH-1:0]                 q,
  output logic [WIDTH*DEPTH-1:0]           taps,
  output logic [$clog2(DEPTH+1)-1:0]       fill,
  output logic                             full
);

  localparam int FW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] stage [DEPTH];
  logic             en_act;

  assign en_act = (en == EN_POL);

  always_ff @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
      fill <= '0;
    end else if (load) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= ad;
      fill <= FW'(DEPTH);
    end else if (en_act) begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      // saturate so a long run of shifts never wraps back to empty
      if (fill != FW'(DEPTH)) fill <= fill + FW'(1);
    end
  end

  always_comb begin
    taps = '0;
    for (int i = 0; i < DEPTH; i++) taps[i*WIDTH +: WIDTH] = stage[i];
  end

  assign q    = stage[DEPTH-1];
  assign full = (fill == FW'(DEPTH));

endmodule

// File: tb/tb_ldffe_pipe.sv
// tb/tb_ldffe_pipe.sv - directed vector bench for ldffe_pipe (both enable polarities, DEPTH=1)
module tb_ldffe_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       srst, load, en;
  logic [3:0] ad, d;
  logic       en_n;
  assign en_n = ~en;

  logic [3:0]  q_a, q_b, q_c;
  logic [11:0] taps_a, taps_b;
  logic [3:0]  taps_c;
  logic [1:0]  fill_a, fill_b;
  logic        fill_c;
  logic        full_a, full_b, full_c;

  ldffe_pipe #(.WIDTH(4), .DEPTH(3), .RST_VAL(4'h0), .EN_POL(1'b1)) dut_a (
    .clk(clk), .srst(srst), .en(en), .load(load), .ad(ad), .d(d),
    .q(q_a), .taps(taps_a), .fill(fill_a), .full(full_a));

  ldffe_pipe #(.WIDTH(4), .DEPTH(3), .RST_VAL(4'h0), .EN_POL(1'b0)) dut_b (
    .clk(clk), .srst(srst), .en(en_n), .load(load), .ad(ad), .d(d),
    .q(q_b), .taps(taps_b), .fill(fill_b), .full(full_b));

  ldffe_pipe #(.WIDTH(4), .DEPTH(1), .RST_VAL(4'h0), .EN_POL(1'b1)) dut_c (
    .clk(clk), .srst(srst), .en(en), .load(load), .ad(ad), .d(d),
    .q(q_c), .taps(taps_c), .fill(fill_c), .full(full_c));

  typedef struct {
    logic        srst, load, en;
    logic [3:0]  ad, d;
    logic [11:0] taps;
    logic [1:0]  fill;
    logic        full;
    logic [3:0]  q1;
    logic        fill1;
  } vec_t;

  vec_t vecs[$];
  int errors = 0;
  int checks = 0;

  function automatic vec_t mk(logic s, logic l, logic e, logic [3:0] a, logic [3:0] dd,
                              logic [11:0] t, logic [1:0] f, logic fu, logic [3:0] q1, logic f1);
    vec_t v;
    v.srst = s; v.load = l; v.en = e; v.ad = a; v.d = dd;
    v.taps = t; v.fill = f; v.full = fu; v.q1 = q1; v.fill1 = f1;
    return v;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d actual=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  initial begin
    srst = 1'b0; load = 1'b0; en = 1'b0; ad = 4'h0; d = 4'h0;

    //           srst load en  ad     d      taps     fill full q1    f1
    vecs.push_back(mk(0, 1, 0, 4'h3, 4'h0, 12'h333, 2'd3, 1, 4'h3, 1)); // load before any reset
    vecs.push_back(mk(1, 1, 1, 4'hF, 4'hF, 12'h000, 2'd0, 0, 4'h0, 0));
    vecs.push_back(mk(0, 0, 1, 4'h0, 4'h1, 12'h001, 2'd1, 0, 4'h1, 1));
    vecs.push_back(mk(0, 0, 1, 4'h0, 4'h2, 12'h012, 2'd2, 0, 4'h2, 1));
    vecs.push_back(mk(0, 0, 1, 4'h0, 4'h3, 12'h123, 2'd3, 1, 4'h3, 1));
    vecs.push_back(mk(0, 0, 1, 4'h0, 4'h4, 12'h234, 2'd3, 1, 4'h4, 1));
    vecs.push_back(mk(0, 0, 0, 4'h9, 4'h5, 12'h234, 2'd3, 1, 4'h4, 1));
    vecs.push_back(mk(0, 0, 0, 4'h9, 4'hA, 12'h234, 2'd3, 1, 4'h4, 1));
    vecs.push_back(mk(0, 0, 0, 4'h9, 4'hF, 12'h234, 2'd3, 1, 4'h4, 1));
    vecs.push_back(mk(0, 1, 0, 4'hA, 4'h5, 12'hAAA, 2'd3, 1, 4'hA, 1));
    vecs.push_back(mk(0, 1, 1, 4'h5, 4'hF, 12'h555, 2'd3, 1, 4'h5, 1));
    vecs.push_back(mk(1, 0, 0, 4'h0, 4'h0, 12'h000, 2'd0, 0, 4'h0, 0));
    vecs.push_back(mk(0, 0, 1, 4'h0, 4'h6, 12'h006, 2'd1, 0, 4'h6, 1));
    vecs.push_back(mk(0, 0, 1, 4'h0, 4'h8, 12'h068, 2'd2, 0, 4'h8, 1));
    vecs.push_back(mk(1, 1, 1, 4'hF, 4'hF, 12'h000, 2'd0, 0, 4'h0, 0)); // reset mid-fill
    vecs.push_back(mk(0, 0, 1, 4'h0, 4'h7, 12'h007, 2'd1, 0, 4'h7, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      srst = vecs[i].srst; load = vecs[i].load; en = vecs[i].en;
      ad = vecs[i].ad; d = vecs[i].d;
      @(posedge clk);
      #1;
      chk("taps",     i, 32'(taps_a), 32'(vecs[i].taps));
      chk("q",        i, 32'(q_a),    32'(vecs[i].taps[11:8]));
      chk("fill",     i, 32'(fill_a), 32'(vecs[i].fill));
      chk("full",     i, 32'(full_a), 32'(vecs[i].full));
      chk("taps_pol0", i, 32'(taps_b), 32'(vecs[i].taps));
      chk("fill_pol0", i, 32'(fill_b), 32'(vecs[i].fill));
      chk("full_pol0", i, 32'(full_b), 32'(vecs[i].full));
      chk("q_d1",     i, 32'(q_c),    32'(vecs[i].q1));
      chk("fill_d1",  i, 32'(fill_c), 32'(vecs[i].fill1));
      chk("full_d1",  i, 32'(full_c), 32'(vecs[i].fill1));
    end

    // disabled edges while d toggles every 3 ns: nothing may move
    @(negedge clk);
    srst = 1'b0; load = 1'b0; en = 1'b0; ad = 4'hC; d = 4'h0;
    fork
      repeat (5) @(posedge clk);
      repeat (16) #3 d = ~d;
    join
    @(negedge clk);
    chk("hold_taps",      100, 32'(taps_a), 32'h007);
    chk("hold_fill",      100, 32'(fill_a), 32'd1);
    chk("hold_taps_pol0", 100, 32'(taps_b), 32'h007);
    chk("hold_fill_pol0", 100, 32'(fill_b), 32'd1);
    chk("hold_q_d1",      100, 32'(q_c),    32'h7);

    // saturation: many more shifts keep fill at DEPTH
    en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      d = 4'(k + 8);
      @(posedge clk);
      #1;
    end
    chk("sat_fill",  101, 32'(fill_a), 32'd3);
    chk("sat_full",  101, 32'(full_a), 32'd1);
    chk("sat_taps",  101, 32'(taps_a), 32'hBCD);
    chk("sat_fill1", 101, 32'(fill_c), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ldffe_pipe.md
LDFFE_PIPE -- requirements
Module: ldffe_pipe

Interface
REQ-001 Parameter WIDTH, default 4, bits per stage; legal range >= 1.
REQ-002 Parameter DEPTH, default 3, number of pipeline stages; legal range >= 1.
REQ-003 Parameter RST_VAL, default 0 (WIDTH bits), value loaded into every stage on reset.
REQ-004 Parameter EN_POL, default 1, active level of en (1 = active-high, 0 = active-low).
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 srst  input  1  reset, synchronous and active-high.
REQ-007 en  input  1  shift enable; active when en == EN_POL.
REQ-008 load  input  1  synchronous parallel load of ad into all stages, active-high.
REQ-009 ad  input  WIDTH  load data.
REQ-010 d  input  WIDTH  serial data into stage 0.
REQ-011 q  output  WIDTH  contents of stage DEPTH-1.
REQ-012 taps  output  WIDTH*DEPTH  all stages; stage i occupies bits [i*WIDTH +: WIDTH].
REQ-013 fill  output  $clog2(DEPTH+1)  count of valid stages, 0..DEPTH.
REQ-014 full  output  1  high when fill == DEPTH.

Function
REQ-015 Per rising edge, the priority SHALL be srst > load > en; at most one action occurs per edge.
REQ-016 Load (srst=0, load=1): every stage <= ad and fill <= DEPTH, regardless of en.
REQ-017 Shift (srst=0, load=0, en active): stage[0] <= d; stage[i] <= stage[i-1] for i = 1..DEPTH-1; fill <= min(fill+1, DEPTH).
REQ-018 Hold (srst=0, load=0, en inactive): all stages and fill SHALL be unchanged, irrespective of d and ad.
REQ-019 Latency: a d value captured on an enabled edge SHALL appear on q after exactly DEPTH enabled edges; disabled edges do not advance data.
REQ-020 fill SHALL saturate at DEPTH; further shifts keep fill = DEPTH and never wrap to 0.
REQ-021 full SHALL be a combinational decode of fill, with no extra cycle of delay.
REQ-022 q, taps, fill and full SHALL change only on rising clk edges; there is no asynchronous path from any input.
REQ-023 DEPTH=1 SHALL behave as a single enabled flip-flop with synchronous load and reset; fill is then 0 or 1.
REQ-024 Neither X nor Z on d SHALL propagate while en is inactive.

Reset
REQ-025 srst=1 at a rising edge: every stage <= RST_VAL, fill <= 0, full <= 0; load and en are ignored that edge.
REQ-026 Reset mid-fill or mid-load SHALL discard all state; the first enabled edge after reset gives fill = 1.
REQ-027 Reset SHALL take effect whenever it is asserted; no prior reset is required for load or shift to work.

Verification (WIDTH=4, DEPTH=3, RST_VAL=0, EN_POL=1 unless stated)
REQ-028 srst=1 for one edge -> q=0000, taps=0, fill=0, full=0.
REQ-029 en=1; d=1,2,3 on three edges -> stage0=3, stage1=2, stage2=q=1, fill=3, full=1; then d=4 -> q=2, fill stays 3.
REQ-030 en=0, d toggling every 3 ns over 5 clock edges -> taps and fill unchanged.
REQ-031 load=1, ad=1010, en=0 -> all stages 1010, fill=3; load=1, en=1, ad=0101, d=1111 on the same edge -> all stages 0101 (load wins).
REQ-032 fill=2, then srst=1 with load=1 and en=1 -> all stages 0000, fill=0; next edge en=1, d=7 -> stage0=7, fill=1, full=0.
REQ-033 EN_POL=0 instance: en=0 shifts and en=1 holds, with the same results as REQ-029 and REQ-030 with en inverted.
